shift_reg_en_n: RTL

SHIFT_REG_EN_N -- requirements
Module: shift_reg_en_n

---
 rtl/shift_reg_pkg.sv | 23 ++
 rtl/shift_bit_cell.sv | 36 +++
 rtl/shift_reg_en_n.sv | 95 +++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// Shared mode encodings and small decode helpers for the enabled shift register.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    HOLD     = 3'b000,
    LOAD     = 3'b001,
    SHL      = 3'b010,
    SHR      = 3'b011,
    ROL      = 3'b100,
    ROR      = 3'b101,
    CLR      = 3'b110,
    HOLD_ALT = 3'b111
  } mode_e;

  function automatic logic is_shift(input mode_e m);
    return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR);
  endfunction

  function automatic logic is_left(input mode_e m);
    return (m == SHL) || (m == ROL);
  endfunction

endpackage

// File: rtl/shift_bit_cell.sv
// One register bit: next-state mux over the mode plus an enabled flop with async reset.
module shift_bit_cell
  import shift_reg_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  en_i,
  input  mode_e mode_i,
  input  logic  load_i,
  input  logic  shl_i,
  input  logic  shr_i,
  output logic  q_o
);

  logic q_d, q_q;

  // Shift vs. rotate differs only at the end bits, so the top resolves shl_i/shr_i.
  always_comb begin
    q_d = q_q;
    case (mode_i)
      LOAD:     q_d = load_i;
      SHL, ROL: q_d = shl_i;
      SHR, ROR: q_d = shr_i;
      CLR:      q_d = 1'b0;
      default:  q_d = q_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     q_q <= 1'b0;
    else if (en_i) q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/shift_reg_en_n.sv
// Enabled shift/rotate/load register with saturating shift count, done pulse and
// direction-following serial output.
module shift_reg_en_n
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       sin,
  output logic [WIDTH-1:0]           q,
  output logic                       sout,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mode_e          mode_s;
  logic [WIDTH-1:0] q_w;
  logic [CW-1:0]  cnt_d, cnt_q;
  logic           done_d, done_q;
  logic           left_d, left_q;

  assign mode_s = mode_e'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic shl_src, shr_src;

    if (i == 0) begin : g_lsb
      assign shl_src = (mode_s == ROL) ? q_w[WIDTH-1] : sin;
    end else begin : g_lsb_n
      assign shl_src = q_w[i-1];
    end

    if (i == WIDTH - 1) begin : g_msb
      assign shr_src = (mode_s == ROR) ? q_w[0] : sin;
    end else begin : g_msb_n
      assign shr_src = q_w[i+1];
    end

    shift_bit_cell u_cell (
      .clk_i  (clk),
      .rst_i  (reset),
      .en_i   (en),
      .mode_i (mode_s),
      .load_i (d[i]),
      .shl_i  (shl_src),
      .shr_i  (shr_src),
      .q_o    (q_w[i])
    );
  end

  // done is recomputed every edge so it can never last more than one cycle.
  always_comb begin
    cnt_d  = cnt_q;
    left_d = left_q;
    done_d = 1'b0;
    if (en) begin
      if (mode_s == LOAD) begin
        cnt_d = '0;
      end else if (mode_s == CLR) begin
        cnt_d  = '0;
        left_d = 1'b1;
      end else if (is_shift(mode_s)) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        done_d = (cnt_q == CNT_LAST);
        left_d = is_left(mode_s);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      left_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      left_q <= left_d;
    end
  end

  assign q    = q_w;
  assign cnt  = cnt_q;
  assign done = done_q;
  assign sout = left_q ? q_w[WIDTH-1] : q_w[0];

endmodule
